// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage carrying payload plus exception sideband (type, PC, delay slot).
// Optional skid entry registers in_ready_o so upstream never sees a combinational path from out_ready_i.
module pipe_stage_skid #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned EXCP_W     = 32,
    parameter int unsigned SKID_EN    = 1,
    parameter int unsigned ZERO_FLUSH = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [EXCP_W-1:0] in_excp_i,
    input  logic [31:0]       in_pc_i,
    input  logic              in_ds_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [EXCP_W-1:0] out_excp_o,
    output logic [31:0]       out_pc_o,
    output logic              out_ds_o,
    output logic [1:0]        occupancy_o
);

    localparam int unsigned W = DATA_W + EXCP_W + 33;

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q, ready_d;
    logic         live_q;
    logic [W-1:0] in_word;
    logic         push, pop;

    assign in_word     = {in_data_i, in_excp_i, in_pc_i, in_ds_i};
    assign out_valid_o = (state_q != ST_EMPTY);
    assign occupancy_o = state_q;
    assign out_data_o  = main_q[W-1 -: DATA_W];
    assign out_excp_o  = main_q[W-DATA_W-1 -: EXCP_W];
    assign out_pc_o    = main_q[32:1];
    assign out_ds_o    = main_q[0];

    // live_q keeps the unregistered variant from accepting during the reset-release cycle.
    assign in_ready_o = (SKID_EN != 0) ? ready_q : (live_q & (~out_valid_o | out_ready_i));

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            if (ZERO_FLUSH != 0) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_d  = in_word;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = in_word;
                    end else if (push) begin
                        if (SKID_EN != 0) begin
                            skid_d  = in_word;
                            state_d = ST_FULL;
                        end
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            live_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i) begin
            assert (state_q != 2'b11);
        end
    end

endmodule
